divider_control: RTL and testbench

- Control FSM that sequences the 4-bit restoring divider datapath: 5-bit remainder in q[8:4], dividend/quotient in q[3:0].
- Sits directly upstream of the datapath and drives its go, shift, loadd, add_sub, loadq0 and q0 inputs.
- Reads the remainder sign bit q[8] back from the datapath.
- Provides a start/ready/done handshake to the surrounding system and flags divide-by-zero.

---
 rtl/divider_pkg.sv | 49 ++++
 rtl/divider_control.sv | 81 ++++++++
 tb/tb_divider_control.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types for the 4-bit restoring divider: FSM states and control bundle.
// Used by divider_control, divider_datapath and the divider top.
package divider_pkg;

  localparam int N_DEF  = 4;
  localparam int CW_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    SUB,
    TEST,
    RESTORE,
    DONE
  } state_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic go;
    logic shift;
    logic loadd;
    logic add_sub;
    logic loadq0;
  } ctrl_t;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    unique case (s)
      IDLE:    c.ready = 1'b1;
      LOAD:    begin c.busy = 1'b1; c.go = 1'b1; end
      SHIFT:   begin c.busy = 1'b1; c.shift = 1'b1; end
      SUB:     begin
        c.busy    = 1'b1;
        c.loadd   = 1'b1;
        c.add_sub = 1'b1;
      end
      TEST:    begin c.busy = 1'b1; c.loadq0 = 1'b1; end
      RESTORE: begin c.busy = 1'b1; c.loadd = 1'b1; end
      DONE:    begin c.busy = 1'b1; c.done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/divider_control.sv
// Control FSM for the restoring divider datapath (rem q[8:4], quot q[3:0]).
// Ports: clk/resetn, start/divisor/q_msb in; ready/busy/done/dbz, datapath controls out.
module divider_control
  import divider_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [4:0] divisor,
  input  logic       q_msb,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       dbz,
  output logic       go,
  output logic       shift,
  output logic       loadd,
  output logic       add_sub,
  output logic       loadq0,
  output logic       q0
);

  state_t        state;
  state_t        nxt;
  ctrl_t         ctrl;
  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == '0);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = SHIFT;
      SHIFT:   nxt = SUB;
      SUB:     nxt = TEST;
      TEST:    nxt = q_msb ? RESTORE
                   : (last ? DONE : SHIFT);
      RESTORE: nxt = last ? DONE : SHIFT;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered alongside the state, from the next state,
  // so they stay glitch-free yet line up with the state they decode.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      ctrl  <= decode(IDLE);
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      state <= nxt;
      ctrl  <= decode(nxt);
      unique case (state)
        IDLE:    if (start) dbz <= (divisor == 5'd0);
        LOAD:    cnt <= CW'(N - 1);
        TEST:    if (!q_msb && !last) cnt <= cnt - CW'(1);
        RESTORE: if (!last) cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  assign ready   = ctrl.ready;
  assign busy    = ctrl.busy;
  assign done    = ctrl.done;
  assign go      = ctrl.go;
  assign shift   = ctrl.shift;
  assign loadd   = ctrl.loadd;
  assign add_sub = ctrl.add_sub;
  assign loadq0  = ctrl.loadq0;
  // Sign of the trial subtract decides the quotient bit.
  assign q0      = ctrl.loadq0 & ~q_msb;

endmodule

// File: tb/tb_divider_control.sv
// Bench for divider_control paired with a behavioural datapath stand-in.
// Results are checked against plain integer division.
module tb_divider_control;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [4:0] divisor;
  logic [3:0] dividend;
  logic       ready, busy, done, dbz;
  logic       go, shift, loadd, add_sub, loadq0, q0;
  logic [8:0] q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  divider_control dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .divisor (divisor),
    .q_msb   (q[8]),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .dbz     (dbz),
    .go      (go),
    .shift   (shift),
    .loadd   (loadd),
    .add_sub (add_sub),
    .loadq0  (loadq0),
    .q0      (q0)
  );

  always_ff @(posedge clk) begin
    if (!resetn) q <= '0;
    else if (go) q <= {5'b0, dividend};
    else if (shift) q <= {q[7:0], 1'b0};
    else if (loadd)
      q[8:4] <= add_sub ? q[8:4] - divisor
                        : q[8:4] + divisor;
    else if (loadq0) q[0] <= q0;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] a,
                        input logic [4:0] b,
                        input bit hold);
    int cyc, zeros, restores;
    logic [3:0] eq, er;
    bit seen;
    if (b == 0) begin
      eq = 4'hf;
      er = a;
    end else begin
      eq = 4'(a / b[3:0]);
      er = 4'(a % b[3:0]);
    end
    zeros = 4 - $countones(eq);
    @(negedge clk);
    check("idle_rdy", 32'(ready), 1);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    cyc = 0; restores = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'($urandom);
      if (cyc == 1) begin
        check("load_go", 32'(go), 1);
        check("dbz_load", 32'(dbz), 32'(b == 0));
      end else begin
        check("go_ign", 32'(go), 0);
      end
      check("onehot",
            32'($countones({go, shift, loadd, loadq0}) <= 1), 1);
      check("as_ld", 32'(add_sub & ~loadd), 0);
      check("busy", 32'(busy), 1);
      if (loadd && !add_sub) restores++;
      if (done) seen = 1;
    end
    if (!hold) start = 1'b0;
    check("seen", 32'(seen), 1);
    check("lat", 32'(cyc), 32'(14 + zeros));
    check("q", 32'(q), 32'({1'b0, er, eq}));
    check("restores", 32'(restores), 32'(zeros));
    check("dbz_done", 32'(dbz), 32'(b == 0));
    check("rdy_done", 32'(ready), 0);
  endtask

  initial begin
    int cnt;
    bit seen;
    resetn   = 1'b0;
    start    = 1'b1;
    divisor  = 5'd0;
    dividend = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(ready), 1);
    check("rst_ctl",
          32'({busy, done, go, shift, loadd, add_sub, loadq0, dbz}), 0);
    start  = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    check("post_rdy", 32'(ready), 1);
    check("post_ctl",
          32'({busy, done, go, shift, loadd, add_sub, loadq0, dbz}), 0);

    run_op(4'd13, 5'd3, 0);
    run_op(4'd15, 5'd1, 0);
    run_op(4'd2,  5'd7, 0);
    run_op(4'd9,  5'd0, 0);
    run_op(4'd13, 5'd5, 0);
    for (int i = 0; i < 20; i++)
      run_op(4'($urandom), 5'($urandom_range(0, 15)), 0);

    // start held high across a whole operation
    run_op(4'd11, 5'd2, 1);
    @(negedge clk);
    check("hold_rdy", 32'(ready), 1);
    @(negedge clk);
    check("hold_go", 32'(go), 1);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("hold_done2", 32'(seen), 1);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("hold_nodone", 32'(cnt), 0);

    // reset while in TEST aborts without done
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 5'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (loadq0) seen = 1;
    end
    check("rst_test_seen", 32'(seen), 1);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_rdy", 32'(ready), 1);
    check("abort_ctl",
          32'({busy, done, go, shift, loadd, add_sub, loadq0}), 0);
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_nodone", 32'(cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
